// File: rtl/tt_um_group1_arbiter.sv
// Eight-requester arbiter with fixed-priority or round-robin selection, a per-grant
// hold timeout and a sticky timeout flag.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst_n    - synchronous active-low reset
//   ena      - design-powered indicator (ignored)
//   ui_in    - request vector, bit i = requester i wants the resource
//   uo_out   - one-hot grant vector (zero while idle)
//   uio_in   - [0] done (release pulse), [1] mode (0 fixed, 1 round-robin)
//   uio_out  - [7] sticky timeout flag, [6:4] granted index, [3:0] zero
//   uio_oe   - constant 8'hF0
module tt_um_group1_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  logic       done;
  logic       mode;
  logic [2:0] winner;
  logic       found;
  logic [2:0] cand;
  logic       unused_ok;

  assign done = uio_in[0];
  assign mode = uio_in[1];
  assign unused_ok = ^{ena, uio_in[7:2]};

  // Winner selection: round-robin scans upward from last+1 with wrap, fixed mode
  // lets the highest set bit overwrite lower ones.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    cand   = 3'd0;
    if (mode) begin
      for (int i = 0; i < 8; i++) begin
        cand = last_q + 3'd1 + 3'(i);
        if (!found && ui_in[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (ui_in[i]) winner = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    if (state_q == IDLE) begin
      if (ui_in != 8'd0) begin
        state_d = GRANT;
        idx_d   = winner;
        cnt_d   = '0;
      end
    end else begin
      if (done || !ui_in[idx_q]) begin
        // Normal release wins over a coinciding expiry, so the flag is untouched.
        state_d = IDLE;
        last_d  = idx_q;
      end else if (cnt_q == CntLast) begin
        state_d = IDLE;
        last_d  = idx_q;
        flag_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  assign uo_out  = (state_q == GRANT) ? (8'd1 << idx_q) : 8'd0;
  assign uio_out = {flag_q, (state_q == GRANT) ? idx_q : 3'd0, 4'd0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_group1_arbiter.sv
module tb_tt_um_group1_arbiter;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  // Reference model: g = granted requester (-1 when idle), held = cycles the
  // current grant has been visible, last = most recently released requester.
  int g;
  int held;
  int last;
  bit flag;

  tt_um_group1_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int j;
    bit found;
    if (!rst_n) begin
      g = -1; held = 0; last = 7; flag = 0;
    end else if (g < 0) begin
      if (ui_in != 8'd0) begin
        found = 0;
        j = 0;
        if (uio_in[1]) begin
          for (int k = 1; k <= 8; k++) begin
            if (!found && ui_in[(last + k) % 8]) begin
              j = (last + k) % 8;
              found = 1;
            end
          end
        end else begin
          for (int k = 7; k >= 0; k--) begin
            if (!found && ui_in[k]) begin
              j = k;
              found = 1;
            end
          end
        end
        g = j;
        held = 1;
      end
    end else if (uio_in[0] || !ui_in[g]) begin
      last = g; g = -1;
    end else if (held == T) begin
      last = g; g = -1; flag = 1;
    end else begin
      held++;
    end
  endtask

  task automatic step();
    int exp_uo;
    int exp_uio;
    model_edge();
    @(posedge clk);
    #1;
    exp_uo  = (g < 0) ? 0 : (1 << g);
    exp_uio = (int'(flag) << 7) | ((g < 0) ? 0 : (g << 4));
    check("uo_out", int'(uo_out), exp_uo);
    check("uio_out", int'(uio_out), exp_uio);
    check("uio_oe", int'(uio_oe), 'hF0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    bit seen;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    g = -1; held = 0; last = 7; flag = 0;
    step();
    step();
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_uo", int'(uo_out), 0);
      check("idle_uio", int'(uio_out), 0);
    end

    // Fixed priority picks highest bit, re-grant after one idle cycle.
    ui_in = 8'h29; uio_in = 8'h00;
    step();
    check("fixed_uo", int'(uo_out), 'h20);
    check("fixed_idx", int'(uio_out[6:4]), 5);
    uio_in = 8'h01;
    step();
    check("done_release", int'(uo_out), 0);
    uio_in = 8'h00;
    step();
    check("regrant", int'(uo_out), 'h20);
    ui_in = 8'h00;
    step();

    // Round-robin rotation starting at index 0 after reset.
    do_reset();
    ui_in = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      uio_in = 8'h02;
      step();
      check("rr_idx", int'(uio_out[6:4]), k % 8);
      check("rr_onehot", int'(uo_out), 1 << (k % 8));
      uio_in = 8'h03;
      step();
      check("rr_gap", int'(uo_out), 0);
    end

    // Timeout: grant held exactly T cycles, flag sticks afterwards.
    ui_in = 8'h04; uio_in = 8'h00;
    cnt = 0; seen = 0;
    for (int n = 0; n < 3 * T && !(seen && uo_out == 8'h00); n++) begin
      step();
      if (uo_out == 8'h04) begin
        cnt++;
        seen = 1;
      end
    end
    check("timeout_len", cnt, T);
    check("timeout_flag", int'(uio_out[7]), 1);
    ui_in = 8'h80;
    step();
    step();
    check("flag_sticky_grant", int'(uio_out), 'hF0);
    uio_in = 8'h01;
    step();
    check("flag_sticky_idle", int'(uio_out[7]), 1);
    ui_in = 8'h00; uio_in = 8'h00;
    step();

    // Request drop releases without flag.
    do_reset();
    ui_in = 8'h08;
    step();
    check("drop_grant", int'(uo_out), 'h08);
    ui_in = 8'h00;
    step();
    check("drop_release", int'(uo_out), 0);
    check("drop_noflag", int'(uio_out[7]), 0);

    // Reset mid-grant, then round-robin starts from 0.
    ui_in = 8'h40;
    step();
    check("pre_rst_grant", int'(uo_out), 'h40);
    rst_n = 1'b0;
    step();
    check("rst_uo", int'(uo_out), 0);
    check("rst_uio", int'(uio_out), 0);
    rst_n = 1'b1; ui_in = 8'hFF; uio_in = 8'h02;
    step();
    check("rst_rr_first", int'(uo_out), 'h01);

    // Randomized phases with varying release and churn rates.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(99) < 5 + ph * 10) ui_in = 8'($urandom);
        if ($urandom_range(9) < 2) ui_in = 8'h00;
        uio_in = {6'($urandom), 1'($urandom), 1'($urandom_range(99) < (ph == 2 ? 0 : 20))};
        rst_n = ($urandom_range(199) != 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
